// File: rtl/fp_mult_arbiter_if.sv
// rtl/fp_mult_arbiter_if.sv - requester and multiplier-side signal bundle for fp_mult_arbiter
interface fp_mult_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0][31:0] req_a_in;
  logic [NUM_REQ-1:0][31:0] req_b_in;
  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic [31:0]              resp_data_out;
  logic [NUM_REQ-1:0]       resp_valid_out;
  logic [31:0]              mult_a_out;
  logic [31:0]              mult_b_out;
  logic                     mult_valid_out;
  logic [31:0]              mult_data_in;
  logic                     mult_valid_in;

  modport master (
    output req_a_in, req_b_in, req_valid_in, mult_data_in, mult_valid_in,
    input  req_ready_out, resp_data_out, resp_valid_out, mult_a_out, mult_b_out, mult_valid_out
  );

  modport slave (
    input  req_a_in, req_b_in, req_valid_in, mult_data_in, mult_valid_in,
    output req_ready_out, resp_data_out, resp_valid_out, mult_a_out, mult_b_out, mult_valid_out
  );
endinterface

// File: rtl/fp_mult_arbiter.sv
// rtl/fp_mult_arbiter.sv - round-robin sharing of one pipelined FP multiplier among NUM_REQ requesters
// Issued requester IDs ride a tag FIFO so the in-order results can be steered back to their owner.
module fp_mult_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 6,
  parameter int TAG_DEPTH    = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  fp_mult_arbiter_if.slave bus,
  output logic             err_out
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int CW  = PW + 1;
  localparam int DW  = $clog2(MULT_LATENCY + 2);

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     tag_mem_q [TAG_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [DW-1:0]      drain_q;
  logic               mult_valid_q;
  logic [31:0]        mult_a_q, mult_b_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [31:0]        resp_data_q;
  logic               err_q;

  logic               grant_vld;
  logic [IDW-1:0]     grant_idx;
  logic               result_live, pop, orphan;

  always_comb begin
    int idx;
    logic [IDW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    // count_q is the occupancy at the start of the cycle; a same-cycle pop frees nothing yet
    if (!rst_in && (count_q != CW'(TAG_DEPTH))) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        cand = IDW'(idx);
        if (!grant_vld && bus.req_valid_in[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    bus.req_ready_out = '0;
    if (grant_vld) bus.req_ready_out[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Results inside the post-reset drain window belong to discarded tags
  assign result_live = bus.mult_valid_in && (drain_q == '0);
  assign pop         = result_live && (count_q != '0);
  assign orphan      = result_live && (count_q == '0);
  assign count_d     = count_q + CW'(grant_vld) - CW'(pop);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drain_q      <= DW'(MULT_LATENCY + 1);
      mult_valid_q <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      mult_valid_q <= grant_vld;
      if (grant_vld) begin
        tag_mem_q[wr_ptr_q] <= grant_idx;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
        mult_a_q            <= bus.req_a_in[grant_idx];
        mult_b_q            <= bus.req_b_in[grant_idx];
      end
      if (pop) begin
        resp_valid_q <= NUM_REQ'(1) << tag_mem_q[rd_ptr_q];
        resp_data_q  <= bus.mult_data_in;
        rd_ptr_q     <= rd_ptr_q + 1'b1;
      end else begin
        resp_valid_q <= '0;
      end
      if (orphan) err_q <= 1'b1;
      if (drain_q != '0) drain_q <= drain_q - 1'b1;
    end
  end

  assign bus.mult_valid_out = mult_valid_q;
  assign bus.mult_a_out     = mult_a_q;
  assign bus.mult_b_out     = mult_b_q;
  assign bus.resp_valid_out = resp_valid_q;
  assign bus.resp_data_out  = resp_data_q;
  assign err_out            = err_q;
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb/tb_fp_mult_arbiter.sv - directed bench for fp_mult_arbiter with a queue-level reference model
module tb_fp_mult_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int MULT_LATENCY = 6;
  localparam int TAG_DEPTH    = 8;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic err_out;

  fp_mult_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  fp_mult_arbiter #(
    .NUM_REQ(NUM_REQ), .MULT_LATENCY(MULT_LATENCY), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus),
    .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // Truncating single-precision multiply; exact for the operands used here
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    int e;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      m = m >> 1;
      e = e + 1;
    end
    return {a[31] ^ b[31], e[7:0], m[45:23]};
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int t);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[t] = 1'b1;
    return v;
  endfunction

  // Multiplier IP model: fixed latency, in order, optional stall and spurious-result injection
  typedef struct { int due; logic [31:0] data; } mres_t;
  mres_t mq[$];
  logic mstall = 1'b0;
  logic mforce = 1'b0;

  always @(negedge clk_in)
    if (bus.mult_valid_out === 1'b1)
      mq.push_back('{due: cyc + MULT_LATENCY, data: fmul(bus.mult_a_out, bus.mult_b_out)});

  always @(posedge clk_in) begin
    #2;
    if (mforce) begin
      bus.mult_valid_in = 1'b1;
      bus.mult_data_in  = 32'hDEADBEEF;
    end else if (!mstall && mq.size() > 0 && mq[0].due <= cyc) begin
      bus.mult_valid_in = 1'b1;
      bus.mult_data_in  = mq[0].data;
      void'(mq.pop_front());
    end else begin
      bus.mult_valid_in = 1'b0;
    end
  end

  // Reference model: in-flight requests as a queue of {owner, expected product}
  typedef struct { int tag; logic [31:0] prod; } tag_t;
  tag_t m_q[$];
  int   m_ptr   = 0;
  int   m_drain = 0;
  bit   m_live  = 1'b0;
  logic               m_issue, m_err;
  logic [31:0]        m_a, m_b, m_resp_d;
  logic [NUM_REQ-1:0] m_resp_v;

  always @(negedge clk_in) begin
    int g;
    int idx;
    logic [NUM_REQ-1:0] e_rdy;
    g     = -1;
    e_rdy = '0;
    if (!rst_in && m_q.size() < TAG_DEPTH)
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (g < 0 && bus.req_valid_in[idx]) g = idx;
      end
    if (g >= 0) e_rdy[g] = 1'b1;
    if (m_live) begin
      chk("req_ready", 32'(bus.req_ready_out), 32'(e_rdy));
      chk("mult_valid", 32'(bus.mult_valid_out), 32'(m_issue));
      chk("mult_a", bus.mult_a_out, m_a);
      chk("mult_b", bus.mult_b_out, m_b);
      chk("resp_valid", 32'(bus.resp_valid_out), 32'(m_resp_v));
      chk("resp_data", bus.resp_data_out, m_resp_d);
      chk("err", 32'(err_out), 32'(m_err));
    end
    if (rst_in) begin
      m_q.delete();
      m_ptr    = 0;
      m_drain  = MULT_LATENCY + 1;
      m_issue  = 1'b0;
      m_a      = '0;
      m_b      = '0;
      m_resp_v = '0;
      m_resp_d = '0;
      m_err    = 1'b0;
      m_live   = 1'b1;
    end else begin
      m_resp_v = '0;
      if (bus.mult_valid_in === 1'b1 && m_drain == 0) begin
        if (m_q.size() == 0) m_err = 1'b1;
        else begin
          m_resp_v = onehot(m_q[0].tag);
          m_resp_d = m_q[0].prod;
          void'(m_q.pop_front());
        end
      end
      if (m_drain > 0) m_drain--;
      m_issue = (g >= 0);
      if (g >= 0) begin
        m_a = bus.req_a_in[g];
        m_b = bus.req_b_in[g];
        m_q.push_back('{tag: g, prod: fmul(bus.req_a_in[g], bus.req_b_in[g])});
        m_ptr = (g + 1) % NUM_REQ;
      end
    end
  end

  // Grant/response logs for the per-scenario literal checks
  int                 g_idx[$];
  int                 g_cyc[$];
  int                 r_cyc[$];
  logic [NUM_REQ-1:0] r_vec[$];
  logic [31:0]        r_data[$];

  always @(negedge clk_in) begin
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.req_ready_out[i] === 1'b1) begin
        g_idx.push_back(i);
        g_cyc.push_back(cyc);
      end
    if ((|bus.resp_valid_out) === 1'b1) begin
      r_vec.push_back(bus.resp_valid_out);
      r_data.push_back(bus.resp_data_out);
      r_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    g_idx.delete();
    g_cyc.delete();
    r_cyc.delete();
    r_vec.delete();
    r_data.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step(2);
    rst_in = 1'b0;
    clear_logs();
  endtask

  logic [31:0] ops_a [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] prods [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

  initial begin
    bus.req_valid_in = '0;
    bus.req_a_in     = '0;
    bus.req_b_in     = '0;

    chk("fmul_2x3", fmul(32'h40000000, 32'h40400000), 32'h40C00000);
    chk("fmul_3x3", fmul(32'h40400000, 32'h40400000), 32'h41100000);
    chk("fmul_1x2", fmul(32'h3F800000, 32'h40000000), 32'h40000000);

    // Single request from requester 2
    do_reset();
    chk("rst_mult_valid", 32'(bus.mult_valid_out), 32'd0);
    chk("rst_mult_a", bus.mult_a_out, 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid_out), 32'd0);
    chk("rst_resp_data", bus.resp_data_out, 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    step(2);
    bus.req_a_in[2] = 32'h40000000;
    bus.req_b_in[2] = 32'h40400000;
    bus.req_valid_in = 4'b0100;
    #1;
    chk("t1_ready", 32'(bus.req_ready_out), 32'h4);
    step(1);
    bus.req_valid_in = '0;
    chk("t1_issue_valid", 32'(bus.mult_valid_out), 32'd1);
    chk("t1_issue_a", bus.mult_a_out, 32'h40000000);
    chk("t1_issue_b", bus.mult_b_out, 32'h40400000);
    step(12);
    chk("t1_ngrants", g_idx.size(), 1);
    chk("t1_nresp", r_vec.size(), 1);
    if (r_vec.size() > 0 && g_cyc.size() > 0) begin
      chk("t1_latency", r_cyc[0] - g_cyc[0], 8);
      chk("t1_resp_vec", 32'(r_vec[0]), 32'h4);
      chk("t1_resp_data", r_data[0], 32'h40C00000);
    end

    // All four requesters continuously valid from reset
    rst_in = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a_in[i] = ops_a[i];
      bus.req_b_in[i] = 32'h40000000;
    end
    bus.req_valid_in = 4'b1111;
    step(2);
    rst_in = 1'b0;
    clear_logs();
    step(24);
    bus.req_valid_in = '0;
    step(12);
    if (g_idx.size() >= 8)
      for (int k = 0; k < 8; k++) begin
        chk("t2_grant_order", g_idx[k], k % 4);
        chk("t2_grant_cycle", g_cyc[k] - g_cyc[0], k);
      end
    if (r_vec.size() >= 4)
      for (int k = 0; k < 4; k++) begin
        chk("t2_resp_vec", 32'(r_vec[k]), 32'(onehot(k)));
        chk("t2_resp_data", r_data[k], prods[k]);
      end
    chk("t2_resp_count", r_vec.size(), g_idx.size());

    // Fairness between requesters 0 and 3 after ptr has moved to 1
    do_reset();
    bus.req_valid_in = 4'b0001;
    step(1);
    bus.req_valid_in = 4'b1001;
    step(8);
    bus.req_valid_in = '0;
    step(12);
    if (g_idx.size() >= 7)
      for (int k = 0; k < 7; k++) chk("t3_alternate", g_idx[k], (k % 2 == 0) ? 0 : 3);

    // Backpressure: results stalled until the tag FIFO fills
    do_reset();
    mstall = 1'b1;
    bus.req_valid_in = 4'b1111;
    step(16);
    chk("t4_grants_at_full", g_idx.size(), TAG_DEPTH);
    chk("t4_ready_at_full", 32'(bus.req_ready_out), 32'd0);
    mstall = 1'b0;
    step(10);
    bus.req_valid_in = '0;
    step(24);
    if (g_cyc.size() > TAG_DEPTH && r_cyc.size() > 0)
      chk("t4_regrant_cycle", g_cyc[TAG_DEPTH], r_cyc[0]);
    chk("t4_resp_count", r_vec.size(), g_idx.size());
    if (r_vec.size() == g_idx.size())
      for (int k = 0; k < r_vec.size(); k++) chk("t4_resp_owner", 32'(r_vec[k]), 32'(onehot(g_idx[k])));

    // Reset while three operations are in flight
    do_reset();
    step(2);
    bus.req_a_in[3] = 32'h40800000;
    bus.req_b_in[3] = 32'h40000000;
    bus.req_valid_in = 4'b0111;
    step(3);
    bus.req_valid_in = '0;
    rst_in = 1'b1;
    step(1);
    rst_in = 1'b0;
    clear_logs();
    bus.req_valid_in = 4'b1000;
    step(1);
    bus.req_valid_in = '0;
    step(14);
    chk("t6_ngrants", g_idx.size(), 1);
    chk("t6_nresp", r_vec.size(), 1);
    chk("t6_err", 32'(err_out), 32'd0);
    if (r_vec.size() > 0 && g_cyc.size() > 0) begin
      chk("t6_resp_vec", 32'(r_vec[0]), 32'h8);
      chk("t6_resp_data", r_data[0], 32'h41000000);
      chk("t6_latency", r_cyc[0] - g_cyc[0], 8);
    end

    // Orphan result long after reset
    do_reset();
    step(20);
    mforce = 1'b1;
    step(1);
    mforce = 1'b0;
    step(4);
    chk("t5_no_resp", r_vec.size(), 0);
    chk("t5_err_set", 32'(err_out), 32'd1);
    step(10);
    chk("t5_err_sticky", 32'(err_out), 32'd1);
    rst_in = 1'b1;
    step(1);
    rst_in = 1'b0;
    chk("t5_err_cleared", 32'(err_out), 32'd0);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
Shares one floating-point multiplier IP (AXI-stream, fixed pipeline latency, always-ready result side) among NUM_REQ requesters in the 3D pipeline, such as the projection, transform and lighting units. It grants requests round-robin, issues one multiply per cycle, and tracks in-flight operation IDs in a tag FIFO. Each result is routed back to its originating requester. It sits between the requester FSMs and the single multiplier instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MULT_LATENCY, 6, multiplier IP latency in cycles from input tvalid to output tvalid
TAG_DEPTH, 8, tag FIFO depth (power of 2, >= MULT_LATENCY+2)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
req_a_in  input  [31:0] x NUM_REQ  operand A per requester (IEEE-754 single)
req_b_in  input  [31:0] x NUM_REQ  operand B per requester
req_valid_in  input  NUM_REQ  request valid per requester, held until accepted
req_ready_out  output  NUM_REQ  one-hot grant; handshake = valid & ready
resp_data_out  output  32  product, broadcast to all requesters
resp_valid_out  output  NUM_REQ  one-hot result strobe, 1 cycle
mult_a_out  output  32  to multiplier s_axis_a_tdata
mult_b_out  output  32  to multiplier s_axis_b_tdata
mult_valid_out  output  1  to multiplier a/b tvalid
mult_data_in  input  32  from multiplier m_axis_result_tdata
mult_valid_in  input  1  from multiplier m_axis_result_tvalid
err_out  output  1  sticky: result arrived with tag FIFO empty

Behaviour:
- Reset values: req_ready_out=0, resp_valid_out=0, resp_data_out=0, mult_valid_out=0, mult_a_out=0, mult_b_out=0, err_out=0. Tag FIFO is empty and the RR pointer is 0.
- Arbitration is combinational in cycle N. The grant goes to the first asserted req_valid_in[i] scanning from ptr upward, modulo NUM_REQ.
  - At most one req_ready_out bit is high per cycle.
  - No grant is made while tag count == TAG_DEPTH. This uses the count at the start of the cycle, even if a pop occurs in the same cycle.
- On a grant to i: ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
- Issue is registered. In cycle N+1: mult_a_out/mult_b_out = operands of i captured at N, mult_valid_out=1, and tag i is pushed into the FIFO.
  - With no grant at N, mult_valid_out=0 at N+1. Operand outputs hold their last value.
- Sustained throughput is one issue per cycle.
- Return path: when mult_valid_in=1 in cycle M, pop the FIFO head t. At M+1: resp_data_out=mult_data_in, resp_valid_out = one-hot(t).
  - Otherwise resp_valid_out=0 and resp_data_out holds.
  - End-to-end latency from the accept cycle to resp_valid_out is MULT_LATENCY+2 cycles.
- Results return in issue order; the multiplier is in-order, so FIFO order equals result order.
- A push and a pop in the same cycle leave the count unchanged. Pointers wrap modulo TAG_DEPTH.
- mult_valid_in with an empty FIFO, outside the drain window: the result is dropped, no resp_valid_out is raised, and err_out <= 1 until reset.
- Reset mid-operation:
  - In-flight tags are discarded.
  - For MULT_LATENCY+1 cycles after rst_in deasserts, mult_valid_in is silently ignored (drain window). err_out is not set and no response is raised.
  - Grants are permitted immediately after reset.
- A requester must hold its operands stable while req_valid_in is high and unaccepted. Changing operands before acceptance is undefined.
- A requester may re-request in the cycle after its accept. Each request is independent of prior results.

Test Plan:
1. Single request: req 2 valid with a=0x40000000 (2.0), b=0x40400000 (3.0).
   -> req_ready_out=4'b0100 in the same cycle; mult_valid_out 1 cycle later with those operands; resp_valid_out=4'b0100 with resp_data_out=0x40C00000 (6.0) exactly 8 cycles after accept (MULT_LATENCY=6).
2. All four requesters valid continuously from reset, operands a=i+1.0, b=2.0.
   -> grants in order 0,1,2,3,0,... one per cycle; responses in the same order with 2.0, 4.0, 6.0, 8.0.
3. Fairness: requesters 0 and 3 valid continuously, after ptr has advanced to 1 by an initial grant to 0.
   -> grants alternate 3,0,3,0,...; neither starves.
4. Backpressure: multiplier model stalls results with mult_valid_in=0 after 8 issues.
   -> at count=8 req_ready_out=0 regardless of requests; the first returned result (pop) re-enables grants on the following cycle; no lost or duplicated responses.
5. Error path: wait 20 cycles after reset, then drive mult_valid_in=1 with no issue outstanding.
   -> no resp_valid_out; err_out=1 and stays 1 until rst_in.
6. Reset mid-flight: 3 ops issued, rst_in pulsed for 1 cycle, model still returns 3 results within the drain window.
   -> no resp_valid_out, err_out=0; a new request right after reset completes normally with the correct tag.
